// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// No timing of its own; consumed by seq_braun_multiplier.
// No flow control here.
package mult_pkg;

    localparam int ST_W      = 2;
    localparam int MAX_W     = 32;
    localparam int MAG_IDX_W = $clog2(MAX_W);

    localparam logic [ST_W-1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY_ENC = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [ST_W-1:0] {
        IDLE = ST_IDLE_ENC,
        BUSY = ST_BUSY_ENC,
        DONE = ST_DONE_ENC
    } state_e;

    // Operand arrives zero-extended; the low WIDTH bits of the result hold |v|,
    // which always fits because |-2^(WIDTH-1)| = 2^(WIDTH-1).
    function automatic logic [MAX_W-1:0] mag(
        input logic [MAX_W-1:0]     v,
        input logic                 is_signed,
        input logic [MAG_IDX_W-1:0] msb
    );
        if (is_signed && v[msb]) begin
            return ~v + MAX_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/Full_adder.sv
// One-bit full adder cell.
// Purely combinational, zero latency.
// No flow control.
module Full_adder (
    input  logic A,
    input  logic B,
    input  logic C_in,
    output logic S,
    output logic C_out
);

    assign S     = A ^ B ^ C_in;
    assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/ripple_adder_n.sv
// WIDTH-bit ripple-carry adder chained from Full_adder cells, carry-in tied low.
// Purely combinational, zero latency.
// No flow control.
module ripple_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;
    assign c_out    = carry[WIDTH];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        Full_adder u_fa (
            .A     (a[gi]),
            .B     (b[gi]),
            .C_in  (carry[gi]),
            .S     (sum[gi]),
            .C_out (carry[gi+1])
        );
    end

endmodule

// File: rtl/seq_braun_multiplier.sv
// Iterative signed/unsigned WIDTH x WIDTH multiplier reusing one ripple adder.
// Latency: accept at edge k, out_valid after edge k+WIDTH+1.
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY/DONE.
module seq_braun_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               SIGNED,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] AB,
    output logic               busy
);

    localparam logic [2*WIDTH-1:0] PROD_ONE = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH);

    state_e               state_q,     state_d;
    logic [WIDTH-1:0]     mcand_q,     mcand_d;
    logic [WIDTH-1:0]     acc_hi_q,    acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q,    acc_lo_d;
    logic                 neg_q,       neg_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q,      busy_d;
    logic [2*WIDTH-1:0]   ab_q,        ab_d;

    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [WIDTH:0]       step;
    logic [2*WIDTH-1:0]   prod;

    ripple_adder_n #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (acc_hi_q),
        .b     (mcand_q),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // acc_lo doubles as the multiplier shift register; its LSB gates the add.
    assign step = acc_lo_q[0] ? {add_cout, add_sum} : {1'b0, acc_hi_q};
    assign prod = {acc_hi_q, acc_lo_q};

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        ab_d        = ab_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d    = WIDTH'(mag(MAX_W'(A), SIGNED, MAG_IDX_W'(WIDTH-1)));
                    acc_lo_d   = WIDTH'(mag(MAX_W'(B), SIGNED, MAG_IDX_W'(WIDTH-1)));
                    acc_hi_d   = '0;
                    neg_d      = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
                    cnt_d      = '0;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    ab_d        = neg_q ? (~prod + PROD_ONE) : prod;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_hi_d = step[WIDTH:1];
                    acc_lo_d = {step[0], acc_lo_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ab_q        <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ab_q        <= ab_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign AB        = ab_q;

endmodule

// File: tb/tb_seq_braun_multiplier.sv
// Scoreboard bench for seq_braun_multiplier at WIDTH=8 with hand-computed products.
module tb_seq_braun_multiplier;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] p;
    } vec_t;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [W-1:0]   A         = '0;
    logic [W-1:0]   B         = '0;
    logic           SIGNED    = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] AB;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;
    logic [2*W-1:0] exp_q[$];

    vec_t vecs[13] = '{
        '{8'h0F, 8'h0F, 1'b0, 16'h00E1},
        '{8'h80, 8'h80, 1'b1, 16'h4000},
        '{8'h80, 8'h7F, 1'b1, 16'hC080},
        '{8'h00, 8'hAB, 1'b0, 16'h0000},
        '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
        '{8'hFF, 8'hFF, 1'b1, 16'h0001},
        '{8'hFD, 8'h05, 1'b1, 16'hFFF1},
        '{8'hC8, 8'h03, 1'b0, 16'h0258},
        '{8'h7F, 8'h7F, 1'b1, 16'h3F01},
        '{8'h80, 8'h80, 1'b0, 16'h4000},
        '{8'h05, 8'hFB, 1'b1, 16'hFFE7},
        '{8'hFF, 8'h01, 1'b0, 16'h00FF},
        '{8'h80, 8'h01, 1'b1, 16'hFF80}
    };

    seq_braun_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .SIGNED    (SIGNED),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .AB        (AB),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: got AB=%0h, expected no output", AB);
            end else begin
                check("product", AB, exp_q.pop_front());
            end
        end
    end

    // Caller is always positioned 1ns after a rising edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] want);
        bit took;
        took     = 1'b0;
        A        = a;
        B        = b;
        SIGNED   = s;
        in_valid = 1'b1;
        for (int c = 0; c < 100 && !took; c++) begin
            took = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (took) begin
            exp_q.push_back(want);
            n_in++;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic latency_check(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check(name, lat, W + 1);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_ab"},        AB,        0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(8'd15, 8'd15, 1'b0, 16'h00E1);
        check("busy_after_accept", busy, 1);
        check("in_ready_after_accept", in_ready, 0);
        latency_check("latency");
        drain();

        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
        drain();

        // Held result under backpressure, with a competing input that must wait.
        out_ready = 1'b0;
        send(8'd12, 8'd10, 1'b0, 16'd120);
        latency_check("latency_bp");
        A        = 8'd7;
        B        = 8'd9;
        SIGNED   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("hold_ab", AB, 120);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("gap_out_valid", out_valid, 0);
        check("gap_in_ready", in_ready, 1);
        check("gap_ab_kept", AB, 120);
        exp_q.push_back(16'd63);
        n_in++;
        @(posedge clk); #1;
        check("pending_accepted", in_ready, 0);
        in_valid = 1'b0;
        drain();

        // Reset mid-iteration discards the in-flight product.
        send(8'd100, 8'd100, 1'b0, 16'h2710);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_values("midreset");
        void'(exp_q.pop_back());
        n_in--;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("no_output_after_reset", out_valid, 0);
        send(8'd3, 8'd5, 1'b0, 16'd15);
        latency_check("latency_after_reset");
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("output_count", n_out, n_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
